// File: rtl/alu_pipe_acc.sv
// alu_pipe_acc: two-stage pipelined eight-operation ALU with an internal
// accumulator, carried flag register, optional saturation, N/Z/V/C flags and
// valid/ready handshakes on the command and result sides.
module alu_pipe_acc #(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       select_i,
  input  logic             acc_sel_i,
  input  logic             clr_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             z_o,
  output logic             n_o,
  output logic             v_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] acc_o
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DEC = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_ADC = 3'b111;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  // Clamp applied after the raw carry/overflow are known: additions pin to
  // all-ones on carry out, subtractions pin to zero on borrow.
  function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] raw,
                                              input logic             carry,
                                              input logic             is_add,
                                              input logic             is_sub);
    logic [WIDTH-1:0] r;
    r = raw;
    if ((SAT_EN != 0) && carry) begin
      if (is_add) r = '1;
      if (is_sub) r = '0;
    end
    return r;
  endfunction

  // Stage 1 (input register)
  logic [WIDTH-1:0] a_p1_q, b_p1_q;
  logic [2:0]       op_p1_q;
  logic             asel_p1_q;
  logic             vld_p1_q;

  // Stage 2 (output register) plus accumulator/carry state
  logic [WIDTH-1:0] s_p2_q;
  logic             c_p2_q, z_p2_q, n_p2_q, v_p2_q;
  logic             vld_p2_q;
  logic [WIDTH-1:0] acc_q;
  logic             cf_q;

  // Next-state values for stage 2
  logic [WIDTH-1:0] s_p2_d;
  logic             c_p2_d, z_p2_d, n_p2_d, v_p2_d;

  logic             s2_advance;
  logic             accept;
  logic             load_p2;

  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH:0]   sum_w;
  logic             is_add, is_sub;

  assign s2_advance = !vld_p2_q || ready_i;
  assign ready_o    = !vld_p1_q || s2_advance;
  assign accept     = valid_i && ready_o;
  assign load_p2    = s2_advance && vld_p1_q;

  // Operand A is taken from the accumulator at compute time, so a chain of
  // accumulating ops sees each predecessor's result with no forwarding logic.
  always_comb begin
    opa    = asel_p1_q ? acc_q : a_p1_q;
    opb    = b_p1_q;
    sum_w  = '0;
    is_add = 1'b0;
    is_sub = 1'b0;
    unique case (op_p1_q)
      OP_ADD: begin
        is_add = 1'b1;
        sum_w  = {1'b0, opa} + {1'b0, opb};
      end
      OP_ADC: begin
        is_add = 1'b1;
        sum_w  = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cf_q};
      end
      OP_INC: begin
        is_add = 1'b1;
        opb    = ONE_W;
        sum_w  = {1'b0, opa} + {1'b0, ONE_W};
      end
      OP_SUB: begin
        is_sub = 1'b1;
        sum_w  = {1'b0, opa} - {1'b0, opb};
      end
      OP_DEC: begin
        is_sub = 1'b1;
        opb    = ONE_W;
        sum_w  = {1'b0, opa} - {1'b0, ONE_W};
      end
      OP_XOR:  sum_w = {1'b0, opa ^ opb};
      OP_AND:  sum_w = {1'b0, opa & opb};
      OP_OR:   sum_w = {1'b0, opa | opb};
      default: sum_w = '0;
    endcase

    c_p2_d = (is_add || is_sub) ? sum_w[WIDTH] : 1'b0;
    v_p2_d = 1'b0;
    if (is_add)
      v_p2_d = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum_w[WIDTH-1] != opa[WIDTH-1]);
    else if (is_sub)
      v_p2_d = (opa[WIDTH-1] != opb[WIDTH-1]) && (sum_w[WIDTH-1] != opa[WIDTH-1]);

    s_p2_d = sat_fn(sum_w[WIDTH-1:0], c_p2_d, is_add, is_sub);
    z_p2_d = (s_p2_d == '0);
    n_p2_d = s_p2_d[WIDTH-1];
  end

  // Stage 1: capture a command on accept; empty when handed on with no refill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      op_p1_q   <= '0;
      asel_p1_q <= 1'b0;
      vld_p1_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_p1_q    <= a_i;
        b_p1_q    <= b_i;
        op_p1_q   <= select_i;
        asel_p1_q <= acc_sel_i;
        vld_p1_q  <= 1'b1;
      end else if (load_p2) begin
        vld_p1_q  <= 1'b0;
      end
    end
  end

  // Stage 2: load result and flags when advancing; data holds otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_p2_q   <= '0;
      c_p2_q   <= 1'b0;
      z_p2_q   <= 1'b0;
      n_p2_q   <= 1'b0;
      v_p2_q   <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (s2_advance) vld_p2_q <= vld_p1_q;
      if (load_p2) begin
        s_p2_q <= s_p2_d;
        c_p2_q <= c_p2_d;
        z_p2_q <= z_p2_d;
        n_p2_q <= n_p2_d;
        v_p2_q <= v_p2_d;
      end
    end
  end

  // Accumulator and carry register follow every completed op; clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cf_q  <= 1'b0;
    end else if (clr_i) begin
      acc_q <= '0;
      cf_q  <= 1'b0;
    end else if (load_p2) begin
      acc_q <= s_p2_d;
      cf_q  <= c_p2_d;
    end
  end

  assign s_o     = s_p2_q;
  assign c_o     = c_p2_q;
  assign z_o     = z_p2_q;
  assign n_o     = n_p2_q;
  assign v_o     = v_p2_q;
  assign valid_o = vld_p2_q;
  assign acc_o   = acc_q;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Directed testbench for alu_pipe_acc: one non-saturating and one saturating
// instance driven by the same stimulus.
module tb_alu_pipe_acc;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, DEC = 3'b010, XOR = 3'b011;
  localparam logic [2:0] AND = 3'b100, OR  = 3'b101, INC = 3'b110, ADC = 3'b111;

  logic       clk_i = 1'b0;
  logic       rst_i, acc_sel_i, clr_i, valid_i, ready_i;
  logic [7:0] a_i, b_i;
  logic [2:0] select_i;

  logic [7:0] s_o, acc_o, ss_o, sacc_o;
  logic       ready_o, c_o, z_o, n_o, v_o, valid_o;
  logic       sready_o, sc_o, sz_o, sn_o, sv_o, svalid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  alu_pipe_acc #(.WIDTH(8), .SAT_EN(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .select_i(select_i),
    .acc_sel_i(acc_sel_i), .clr_i(clr_i), .valid_i(valid_i), .ready_o(ready_o),
    .s_o(s_o), .c_o(c_o), .z_o(z_o), .n_o(n_o), .v_o(v_o), .valid_o(valid_o),
    .ready_i(ready_i), .acc_o(acc_o)
  );

  alu_pipe_acc #(.WIDTH(8), .SAT_EN(1)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .select_i(select_i),
    .acc_sel_i(acc_sel_i), .clr_i(clr_i), .valid_i(valid_i), .ready_o(sready_o),
    .s_o(ss_o), .c_o(sc_o), .z_o(sz_o), .n_o(sn_o), .v_o(sv_o), .valid_o(svalid_o),
    .ready_i(ready_i), .acc_o(sacc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic asel);
    valid_i   = 1'b1;
    select_i  = op;
    a_i       = a;
    b_i       = b;
    acc_sel_i = asel;
  endtask

  // Issue one op, then wait for its result (accept edge + completion edge).
  task automatic op_wait(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    drive(op, a, b, 1'b0);
    tick();
    valid_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clr_i = 1'b0;
    a_i = '0; b_i = '0; select_i = '0; acc_sel_i = 1'b0;
    tick();
    tick();
    chk("rst_s", s_o, 8'h00);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_acc", acc_o, 8'h00);
    rst_i = 1'b0;
    tick();

    // ADD with carry out, checking latency
    drive(ADD, 8'hF0, 8'h20, 1'b0);
    tick();
    valid_i = 1'b0;
    chk("add_lat_valid", valid_o, 1'b0);
    tick();
    chk("add_valid", valid_o, 1'b1);
    chk("add_s", s_o, 8'h10);
    chk("add_czv", {c_o, z_o, v_o}, 3'b100);

    op_wait(ADC, 8'h00, 8'h00);
    chk("adc_s", s_o, 8'h01);
    chk("adc_c", c_o, 1'b0);

    op_wait(SUB, 8'h80, 8'h01);
    chk("sub_s", s_o, 8'h7F);
    chk("sub_cvn", {c_o, v_o, n_o}, 3'b010);

    op_wait(DEC, 8'h00, 8'h00);
    chk("dec_s", s_o, 8'hFF);
    chk("dec_cnv", {c_o, n_o, v_o}, 3'b110);

    op_wait(INC, 8'hFF, 8'h00);
    chk("inc_s", s_o, 8'h00);
    chk("inc_cz", {c_o, z_o}, 2'b11);

    op_wait(XOR, 8'hAA, 8'h0F);
    chk("xor_s", s_o, 8'hA5);
    chk("xor_cvn", {c_o, v_o, n_o}, 3'b001);

    op_wait(OR, 8'h50, 8'h05);
    chk("or_s", s_o, 8'h55);

    // Accumulator chain, operand A input deliberately nonzero
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_acc", acc_o, 8'h00);
    drive(ADD, 8'h77, 8'h05, 1'b1);
    tick();
    tick();
    chk("acc1_s", s_o, 8'h05);
    tick();
    valid_i = 1'b0;
    chk("acc2_s", s_o, 8'h0A);
    tick();
    chk("acc3_s", s_o, 8'h0F);
    chk("acc3_acc", acc_o, 8'h0F);
    tick();
    chk("drain_valid", valid_o, 1'b0);
    chk("drain_s_hold", s_o, 8'h0F);

    // Backpressure: three ops issued while the sink stalls
    ready_i = 1'b0;
    drive(ADD, 8'h01, 8'h01, 1'b0);
    tick();
    drive(XOR, 8'h0F, 8'hF0, 1'b0);
    tick();
    drive(AND, 8'h3C, 8'h0F, 1'b0);
    chk("bp_ready_low", ready_o, 1'b0);
    chk("bp_s_first", s_o, 8'h02);
    tick();
    chk("bp_s_stable1", s_o, 8'h02);
    chk("bp_valid_hold", valid_o, 1'b1);
    tick();
    chk("bp_s_stable2", s_o, 8'h02);
    ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("bp_second", s_o, 8'hFF);
    chk("bp_second_valid", valid_o, 1'b1);
    tick();
    chk("bp_third", s_o, 8'h0C);
    chk("bp_third_valid", valid_o, 1'b1);
    tick();
    chk("bp_empty", valid_o, 1'b0);

    // Saturation versus wrap on the two instances
    op_wait(ADD, 8'hF0, 8'h20);
    chk("sat_add_s", ss_o, 8'hFF);
    chk("sat_add_c", sc_o, 1'b1);
    chk("wrap_add_s", s_o, 8'h10);
    op_wait(SUB, 8'h10, 8'h20);
    chk("sat_sub_s", ss_o, 8'h00);
    chk("sat_sub_cz", {sc_o, sz_o}, 2'b11);
    chk("wrap_sub_s", s_o, 8'hF0);
    chk("wrap_sub_cn", {c_o, n_o}, 2'b11);

    // Clear on the completion edge
    drive(ADD, 8'h03, 8'h04, 1'b0);
    tick();
    valid_i = 1'b0;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_done_s", ss_o, 8'h07);
    chk("clr_done_valid", svalid_o, 1'b1);
    chk("clr_done_acc", sacc_o, 8'h00);
    chk("clr_done_acc_nosat", acc_o, 8'h00);

    // Reset with two ops in flight
    drive(ADD, 8'h11, 8'h22, 1'b0);
    tick();
    drive(ADD, 8'h01, 8'h02, 1'b0);
    tick();
    valid_i = 1'b0;
    chk("mid_acc_pre", acc_o, 8'h33);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_s", s_o, 8'h00);
    chk("mid_rst_flags", {c_o, z_o, n_o, v_o}, 4'b0000);
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_acc", acc_o, 8'h00);
    chk("mid_rst_ready", ready_o, 1'b1);
    rst_i = 1'b0;
    tick();
    chk("post_rst_valid1", valid_o, 1'b0);
    tick();
    chk("post_rst_valid2", valid_o, 1'b0);
    chk("post_rst_acc", acc_o, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
